// File: rtl/b10_pkg.sv
// rtl/b10_pkg.sv - shared BCD constants, state encoding and digit check for the countdown core.
package b10_pkg;

  localparam int BCD_W = 4;
  localparam logic [3:0] MAX_DIGIT = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_bcd_digit(input logic [3:0] d);
    return (d <= MAX_DIGIT);
  endfunction

endpackage

// File: rtl/b10_countdown_if.sv
// rtl/b10_countdown_if.sv - control/status bundle between the timer FSM, the countdown core and the display.
interface b10_countdown_if #(
  parameter int N_DIGITS = 4
);
  logic                  load;
  logic [4*N_DIGITS-1:0] d_in;
  logic                  start;
  logic                  tick;
  logic [4*N_DIGITS-1:0] q;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output load, d_in, start, tick,
    input  q, busy, done, err
  );

  modport slave (
    input  load, d_in, start, tick,
    output q, busy, done, err
  );
endinterface

// File: rtl/b10_halfsubtractor.sv
// rtl/b10_halfsubtractor.sv - one BCD digit minus a borrow-in, producing a borrow-out.
import b10_pkg::*;

module b10_halfsubtractor (
  input  logic [3:0] x3_x0,
  input  logic       bin,
  output logic [3:0] s3_s0,
  output logic       bout
);

  always_comb begin
    s3_s0 = x3_x0;
    bout  = 1'b0;
    if (bin) begin
      if (x3_x0 == 4'd0) begin
        s3_s0 = MAX_DIGIT;
        bout  = 1'b1;
      end else begin
        s3_s0 = x3_x0 - 4'd1;
      end
    end
  end

endmodule

// File: rtl/b10_countdown.sv
// rtl/b10_countdown.sv - N-digit BCD down counter with load/start/tick and terminal pulse.
// Optional periodic reload on reaching zero: B10_COUNTDOWN_AUTORELOAD_EN.
import b10_pkg::*;

module b10_countdown #(
  parameter int N_DIGITS = 4
) (
  input  logic          clock,
  input  logic          reset,
  b10_countdown_if.slave bus
);

  localparam int W = BCD_W * N_DIGITS;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]      q_r;
  logic [W-1:0]      q_dec;
  logic [1:0]        state;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [N_DIGITS:0] borrow;
  logic              d_valid;
  logic              unused_bout;

`ifdef B10_COUNTDOWN_AUTORELOAD_EN
  logic [W-1:0]      reload_r;
`endif

  // Digit 0 always borrows, so the chain computes q - 1.
  assign borrow[0] = 1'b1;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    b10_halfsubtractor u_hs (
      .x3_x0 (q_r[BCD_W*k +: BCD_W]),
      .bin   (borrow[k]),
      .s3_s0 (q_dec[BCD_W*k +: BCD_W]),
      .bout  (borrow[k+1])
    );
  end

  // The top borrow can never fire because RUN is never held at zero.
  assign unused_bout = borrow[N_DIGITS];

  always_comb begin
    d_valid = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!is_bcd_digit(bus.d_in[BCD_W*k +: BCD_W])) d_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_r    <= '0;
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
`ifdef B10_COUNTDOWN_AUTORELOAD_EN
      reload_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      if (bus.load) begin
        if (d_valid) begin
          q_r    <= bus.d_in;
          state  <= ST_IDLE;
          busy_r <= 1'b0;
`ifdef B10_COUNTDOWN_AUTORELOAD_EN
          reload_r <= bus.d_in;
`endif
        end else begin
          err_r <= 1'b1;
        end
      end else if (bus.start && state != ST_RUN) begin
        if (q_r != '0) begin
          state  <= ST_RUN;
          busy_r <= 1'b1;
        end else begin
          state  <= ST_DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end else if (state == ST_RUN && bus.tick) begin
        if (q_r == ONE) begin
          done_r <= 1'b1;
`ifdef B10_COUNTDOWN_AUTORELOAD_EN
          if (reload_r != '0) begin
            q_r <= reload_r;
          end else begin
            q_r    <= '0;
            state  <= ST_DONE;
            busy_r <= 1'b0;
          end
`else
          q_r    <= '0;
          state  <= ST_DONE;
          busy_r <= 1'b0;
`endif
        end else begin
          q_r <= q_dec;
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_b10_countdown.sv
// tb/tb_b10_countdown.sv - directed vectors with a queued scoreboard for b10_countdown.
module tb_b10_countdown;

  typedef struct {
    int          id;
    logic [15:0] q;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  logic clock;
  logic reset;
  exp_t exp_q[$];
  int   n_compared;
  int   n_failed;
  int   vec_id;

  b10_countdown_if #(.N_DIGITS(4)) bus ();

  b10_countdown #(.N_DIGITS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic rst, input logic ld, input logic [15:0] d,
                      input logic st, input logic tk,
                      input logic [15:0] eq, input logic eb, input logic ed, input logic ee);
    exp_t e;
    @(negedge clock);
    reset     = rst;
    bus.load  = ld;
    bus.d_in  = d;
    bus.start = st;
    bus.tick  = tk;
    e.id   = vec_id;
    e.q    = eq;
    e.busy = eb;
    e.done = ed;
    e.err  = ee;
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (bus.q !== e.q || bus.busy !== e.busy || bus.done !== e.done || bus.err !== e.err) begin
          n_failed++;
          $display("FAIL vec%0d: got q=%h busy=%b done=%b err=%b, expected q=%h busy=%b done=%b err=%b",
                   e.id, bus.q, bus.busy, bus.done, bus.err, e.q, e.busy, e.done, e.err);
        end
      end
    end
  end

  initial begin
    logic [15:0] dec50 [10];
    dec50 = '{16'h0049, 16'h0048, 16'h0047, 16'h0046, 16'h0045,
              16'h0044, 16'h0043, 16'h0042, 16'h0041, 16'h0040};
    n_compared = 0;
    n_failed   = 0;
    vec_id     = 0;
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.d_in   = '0;
    bus.start  = 1'b0;
    bus.tick   = 1'b0;

    step(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
`ifdef B10_COUNTDOWN_AUTORELOAD_EN
    step(0, 1, 16'h0002, 0, 0, 16'h0002, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 16'h0002, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 16'h0000, 0, 1, 16'h0001, 1, 0, 0);
      step(0, 0, 16'h0000, 0, 1, 16'h0002, 1, 1, 0);
    end
`else
    // Count 3 down to 0 with tick held high, then stay in DONE.
    step(0, 1, 16'h0003, 0, 0, 16'h0003, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 1, 16'h0003, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0002, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0001, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 1, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    // Borrow ripples across three digits, then hold.
    step(0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 16'h1000, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0999, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 0, 16'h0999, 1, 0, 0);
    // Non-BCD load rejected; err sticks through a later valid load.
    step(0, 1, 16'h00A5, 0, 0, 16'h0999, 1, 0, 1);
    step(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
    step(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1);
    step(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 1);
    // Reset mid-run clears everything, err included.
    step(0, 1, 16'h0050, 0, 0, 16'h0050, 0, 0, 1);
    step(0, 0, 16'h0000, 1, 0, 16'h0050, 1, 0, 1);
    for (int i = 0; i < 10; i++) step(0, 0, 16'h0000, 0, 1, dec50[i], 1, 0, 1);
    step(1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 0);
    // Load beats start; tick ignored outside RUN; start ignored in RUN.
    step(0, 1, 16'h0007, 1, 0, 16'h0007, 0, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0007, 0, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 16'h0007, 1, 0, 0);
    step(0, 0, 16'h0000, 1, 0, 16'h0007, 1, 0, 0);
    step(0, 0, 16'h0000, 0, 1, 16'h0006, 1, 0, 0);
`endif
    @(negedge clock);
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.tick  = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_compared++;
      n_failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
